// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencing for the 5-stage pipeline: per-stage write enables and flushes
// for load-use, MEM-resolved redirects and multi-cycle data-memory accesses.
module pipe_hazard_ctrl #(
  parameter int REG_W   = 6,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memRead,
  input  logic [REG_W-1:0] ex_writeDataReg,
  input  logic [1:0]       mem_jump,
  input  logic [1:0]       mem_branch,
  input  logic             mem_zero,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_redirect,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             bus_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ABORT    = 2'b10
  } state_e;

  localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic in_abort;
  logic mem_stall;
  logic taken;
  logic load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Hazard terms are masked while rst is high so the enables show the free-running values.
  always_comb begin
    in_abort  = (state_q == ABORT);
    mem_stall = ~rst & mem_req & ~dmem_ready & ~in_abort;
    taken     = ~rst & ((|mem_jump) |
                        ((mem_branch == 2'b01) &  mem_zero) |
                        ((mem_branch == 2'b10) & ~mem_zero));
    load_use  = ~rst & ex_memRead & (|ex_writeDataReg) &
                ((ex_writeDataReg == id_rs) |
                 (id_uses_rt & (ex_writeDataReg == id_rt)));
  end

  always_comb begin
    pc_write     = 1'b1;
    pc_redirect  = 1'b0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (mem_stall) begin
      // Redirect is deferred: the branch sits in MEM until the access completes.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (taken) begin
      pc_redirect  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    stall_cnt_d = pc_write ? stall_cnt_q : sat_inc(stall_cnt_q);
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d = ABORT;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ABORT:   state_d = RUN;
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus_err   = in_abort;
  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector scoreboard bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 6;
  localparam int CNT_W = 4;

  // {pc_write, pc_redirect, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
  //  ex_mem_write, ex_mem_flush, mem_wb_flush, bus_err}
  localparam logic [9:0] C_RUN = 10'b1_0_1_0_1_0_1_0_0_0;
  localparam logic [9:0] C_LU  = 10'b0_0_0_0_1_1_1_0_0_0;
  localparam logic [9:0] C_TKN = 10'b1_1_1_1_1_1_1_1_0_0;
  localparam logic [9:0] C_MS  = 10'b0_0_0_0_0_0_0_0_1_0;
  localparam logic [9:0] C_ABL = 10'b0_0_0_0_1_1_1_0_0_1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_writeDataReg = '0;
  logic             id_uses_rt = 1'b0, ex_memRead = 1'b0;
  logic [1:0]       mem_jump = '0, mem_branch = '0;
  logic             mem_zero = 1'b0, mem_req = 1'b0, dmem_ready = 1'b0;
  logic             pc_write, pc_redirect, if_id_write, if_id_flush;
  logic             id_ex_write, id_ex_flush, ex_mem_write, ex_mem_flush;
  logic             mem_wb_flush, bus_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct {
    string            name;
    logic [9:0]       ctl;
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  pipe_hazard_ctrl #(.REG_W(REG_W), .TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memRead(ex_memRead), .ex_writeDataReg(ex_writeDataReg),
    .mem_jump(mem_jump), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_redirect(pc_redirect),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .bus_err(bus_err),
    .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: every sampled cycle with a pending expectation is checked.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [9:0] ctl;
      e   = sb.pop_front();
      ctl = {pc_write, pc_redirect, if_id_write, if_id_flush, id_ex_write,
             id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_flush, bus_err};
      n_vec++;
      if (ctl !== e.ctl || state !== e.st || stall_cnt !== e.cnt) begin
        n_err++;
        $display("FAIL %s: got ctl=%b state=%0d cnt=%0d, expected ctl=%b state=%0d cnt=%0d",
                 e.name, ctl, state, stall_cnt, e.ctl, e.st, e.cnt);
      end
    end
  end

  task automatic vec(input string name, input logic r,
                     input int rs, input int rt, input logic urt,
                     input logic mr, input int wdr,
                     input logic [1:0] jmp, input logic [1:0] br, input logic z,
                     input logic req, input logic rdy,
                     input logic [9:0] ectl, input logic [1:0] est, input int ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    id_rs           = REG_W'(rs);
    id_rt           = REG_W'(rt);
    id_uses_rt      = urt;
    ex_memRead      = mr;
    ex_writeDataReg = REG_W'(wdr);
    mem_jump        = jmp;
    mem_branch      = br;
    mem_zero        = z;
    mem_req         = req;
    dmem_ready      = rdy;
    e.name = name;
    e.ctl  = ectl;
    e.st   = est;
    e.cnt  = CNT_W'(ecnt);
    sb.push_back(e);
  endtask

  initial begin
    //   name           rst rs rt urt mr wdr jmp    br     z    req  rdy   ctl    st cnt
    vec("reset_idle",   1, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 0, 0, C_RUN, 0, 0);
    vec("reset_masked", 1, 5, 0, 0, 1, 5, 2'd0, 2'b00, 0, 1, 0, C_RUN, 0, 0);
    vec("run_idle",     0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 0, 0, C_RUN, 0, 0);
    vec("load_use_rs",  0, 5, 0, 0, 1, 5, 2'd0, 2'b00, 0, 0, 0, C_LU,  0, 0);
    vec("lu_release",   0, 5, 0, 0, 0, 5, 2'd0, 2'b00, 0, 0, 0, C_RUN, 0, 1);
    vec("zero_reg",     0, 0, 0, 0, 1, 0, 2'd0, 2'b00, 0, 0, 0, C_RUN, 0, 1);
    vec("rt_unused",    0, 3, 7, 0, 1, 7, 2'd0, 2'b00, 0, 0, 0, C_RUN, 0, 1);
    vec("rt_used",      0, 3, 7, 1, 1, 7, 2'd0, 2'b00, 0, 0, 0, C_LU,  0, 1);
    vec("idle_a",       0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 0, 0, C_RUN, 0, 2);
    vec("beq_taken_lu", 0, 5, 0, 0, 1, 5, 2'd0, 2'b01, 1, 0, 0, C_TKN, 0, 2);
    vec("bne_nt_lu",    0, 5, 0, 0, 1, 5, 2'd0, 2'b10, 1, 0, 0, C_LU,  0, 2);
    vec("jump",         0, 0, 0, 0, 0, 0, 2'd2, 2'b00, 0, 0, 0, C_TKN, 0, 3);
    vec("bne_taken",    0, 0, 0, 0, 0, 0, 2'd0, 2'b10, 0, 0, 0, C_TKN, 0, 3);
    vec("br_reserved",  0, 0, 0, 0, 0, 0, 2'd0, 2'b11, 1, 0, 0, C_RUN, 0, 3);
    vec("mw_enter",     0, 0, 0, 0, 0, 0, 2'd1, 2'b00, 0, 1, 0, C_MS,  0, 3);
    vec("mw_wait1",     0, 0, 0, 0, 0, 0, 2'd1, 2'b00, 0, 1, 0, C_MS,  1, 4);
    vec("mw_wait2",     0, 0, 0, 0, 0, 0, 2'd1, 2'b00, 0, 1, 0, C_MS,  1, 5);
    vec("mw_ready_tkn", 0, 0, 0, 0, 0, 0, 2'd1, 2'b00, 0, 1, 1, C_TKN, 1, 6);
    vec("mw_done",      0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 0, 0, C_RUN, 0, 6);
    vec("to_enter",     0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 1, 0, C_MS,  0, 6);
    vec("to_wait1",     0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 1, 0, C_MS,  1, 7);
    vec("to_wait2",     0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 1, 0, C_MS,  1, 8);
    vec("to_wait3",     0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 1, 0, C_MS,  1, 9);
    vec("abort_lu",     0, 5, 0, 0, 1, 5, 2'd0, 2'b00, 0, 1, 0, C_ABL, 2, 10);
    vec("after_abort",  0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 0, 0, C_RUN, 0, 11);
    vec("late_enter",   0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 1, 0, C_MS,  0, 11);
    vec("late_wait1",   0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 1, 0, C_MS,  1, 12);
    vec("late_wait2",   0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 1, 0, C_MS,  1, 13);
    vec("late_ready",   0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 1, 1, C_RUN, 1, 14);
    vec("late_no_err",  0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 0, 0, C_RUN, 0, 14);
    vec("sat_lu1",      0, 5, 0, 0, 1, 5, 2'd0, 2'b00, 0, 0, 0, C_LU,  0, 14);
    vec("sat_lu2",      0, 5, 0, 0, 1, 5, 2'd0, 2'b00, 0, 0, 0, C_LU,  0, 15);
    vec("sat_lu3",      0, 5, 0, 0, 1, 5, 2'd0, 2'b00, 0, 0, 0, C_LU,  0, 15);
    vec("sat_hold",     0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 0, 0, C_RUN, 0, 15);
    vec("ar_enter",     0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 1, 0, C_MS,  0, 15);
    vec("ar_wait",      0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 1, 0, C_MS,  1, 15);
    vec("async_reset",  1, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 1, 0, C_RUN, 0, 0);
    vec("post_reset",   0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 0, 0, 0, C_RUN, 0, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing unit for the 5-stage MIPS pipeline: generates per-stage write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves three hazard types:
  - load-use data hazards (ID against EX);
  - control redirects from branch/jump resolved in MEM;
  - multi-cycle data-memory accesses, via a ready handshake with timeout.
- Keeps a saturating stall counter for performance debug.

Parameters:
- REG_W, 6, register-address width (matches writeDataReg fields)
- TIMEOUT, 16, max MEM_WAIT cycles before bus error abort (>=2)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs  in  REG_W  source reg 1 of instruction in ID
- id_rt  in  REG_W  source reg 2 of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_memRead  in  1  instruction in EX is a load
- ex_writeDataReg  in  REG_W  destination reg of EX instruction
- mem_jump  in  2  jump field of MEM instruction (nonzero = jump)
- mem_branch  in  2  00 none, 01 beq, 10 bne, 11 reserved (never taken)
- mem_zero  in  1  ALU zero flag latched into MEM
- mem_req  in  1  MEM instruction does memRead or memWrite
- dmem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC register enable
- pc_redirect  out  1  select branch/jump target for PC
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID load bubble
- id_ex_write  out  1  ID/EX enable
- id_ex_flush  out  1  ID/EX load bubble
- ex_mem_write  out  1  EX/MEM enable
- ex_mem_flush  out  1  EX/MEM load bubble
- mem_wb_flush  out  1  MEM/WB load bubble
- bus_err  out  1  one-cycle pulse on access timeout
- state  out  2  FSM state (debug)
- stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:

FSM states:
- RUN=00, MEM_WAIT=01, ABORT=10; 11 is illegal and goes to RUN.

Reset (async, rst=1):
- state=RUN, wait counter=0, stall_cnt=0.
- All flush outputs=0, bus_err=0.
- Write enables follow the RUN equations below with all hazard terms forced to 0, so pc_write=if_id_write=id_ex_write=ex_mem_write=1.
- Deasserting rst mid-access abandons that access; no bus_err is produced.

Hazard definitions (combinational):
- mem_stall = mem_req & ~dmem_ready & (state!=ABORT)
- taken = (mem_jump!=0) | (mem_branch==01 & mem_zero) | (mem_branch==10 & ~mem_zero)
- load_use = ex_memRead & ex_writeDataReg!=0 & (ex_writeDataReg==id_rs | (id_uses_rt & ex_writeDataReg==id_rt))

Priority: mem_stall > taken > load_use.
- mem_stall:
  - pc_write, if_id_write, id_ex_write, ex_mem_write = 0
  - mem_wb_flush=1
  - all other flushes 0
  - pc_redirect=0 (a redirect is held until access completes)
- else taken:
  - pc_write=1, pc_redirect=1
  - if_id_flush=id_ex_flush=ex_mem_flush=1
  - load_use ignored (its ID instruction is squashed)
- else load_use:
  - pc_write=0, if_id_write=0, id_ex_flush=1
  - exactly one bubble, since the load advances to MEM next cycle
- else: all enables 1, all flushes 0.

Transitions:
- RUN -> MEM_WAIT when mem_stall; wait counter loads 1.
- MEM_WAIT:
  - dmem_ready -> RUN.
  - Else counter increments; when counter==TIMEOUT-1 and still not ready -> ABORT.
- ABORT lasts exactly one cycle:
  - bus_err=1;
  - mem_stall is forced 0, so the pipeline advances and the access is treated as complete;
  - taken/load_use are evaluated normally;
  - next state RUN.
- dmem_ready asserting on the same cycle as the timeout compare wins: go to RUN, no bus_err.

Stall counter:
- stall_cnt increments on each rising edge where pc_write=0.
- Holds at 2^CNT_W-1.

Latency:
- All control outputs are combinational from inputs and state; no added pipeline delay.

Test Plan:
- Load-use: ex_memRead=1, ex_writeDataReg=5, id_rs=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; next cycle (ex_memRead=0) all enables 1; stall_cnt=1.
- Zero-register and rt gating:
  - ex_writeDataReg=0, id_rs=0 -> no stall.
  - id_rt match with id_uses_rt=0 -> no stall.
  - id_rt match with id_uses_rt=1 -> stall.
- Branch: mem_branch=01, mem_zero=1 with load_use active -> pc_redirect=1 and if_id/id_ex/ex_mem flush=1 for one cycle, no load-use stall. Repeat with mem_branch=10, mem_zero=1 -> not taken.
- Mem wait: mem_req=1, dmem_ready low 3 cycles then high:
  - state MEM_WAIT for 3 cycles, all writes 0, mem_wb_flush=1;
  - a concurrent taken redirect appears only on the ready cycle;
  - stall_cnt=3.
- Timeout: TIMEOUT=4, dmem_ready held 0 -> ABORT entered after 4 stalled cycles, bus_err pulses exactly one cycle, then RUN. Variant: ready on the final cycle -> no bus_err.
- Async reset asserted mid-MEM_WAIT between clock edges -> state=00, stall_cnt=0, bus_err=0 immediately, with no clock edge required.
